shift_sub_divider: RTL

- Sequential restoring divider; the inverse operation to the team's shift-add multiplier.
- Takes a 2N-bit dividend, which can be a multiplier product, and an N-bit divisor.
- Returns an N-bit quotient and an N-bit remainder after N iteration cycles.
- Uses the same start/ready handshake as the multiplier, so both blocks share one bench style and one controller.

---
 rtl/shift_sub_divider.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder in N cycles.
// Optional macro DIV_OVF_EN: detect quotient overflow (incl. divide-by-zero) at start and skip the iteration.
module shift_sub_divider #(
   parameter int N = 16
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [2*N-1:0] A,
   input  logic [N-1:0]   B,
   output logic [N-1:0]   Q,
   output logic [N-1:0]   R,
   output logic           ovf,
   output logic           ready
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: a request is taken on any rising edge where ready=1 and start=1.
   // ready=0 marks RUN, during which start, A and B are ignored; Q/R/ovf change
   // only on the completing edge (or on an overflow start when enabled).

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N:0]   work_q, work_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   q_q, q_d;
   logic [N-1:0]   r_q, r_d;
   logic           ready_q, ready_d;

   logic [2*N:0]   shifted;
   logic [N:0]     rem_sh;
   logic [N:0]     trial;
   logic           take;
   logic [N:0]     iter_rem;
   logic [2*N:0]   iter_work;

`ifdef DIV_OVF_EN
   logic           ovf_q, ovf_d;
   logic           ovf_cond;
   assign ovf_cond = (A[2*N-1:N] >= B);
`endif

   // One restoring step: shift left, try subtracting the divisor from the upper part.
   always_comb begin
      shifted   = {work_q[2*N-1:0], 1'b0};
      rem_sh    = shifted[2*N:N];
      trial     = rem_sh - {1'b0, b_q};
      take      = (rem_sh >= {1'b0, b_q});
      iter_rem  = take ? trial : rem_sh;
      iter_work = {iter_rem, shifted[N-1:1], take};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      ready_d = ready_q;
`ifdef DIV_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
`ifdef DIV_OVF_EN
               if (ovf_cond) begin
                  state_d = DONE;
                  ready_d = 1'b1;
                  ovf_d   = 1'b1;
                  q_d     = '1;
                  r_d     = A[N-1:0];
               end else begin
                  work_d  = {1'b0, A};
                  b_d     = B;
                  cnt_d   = CW'(N);
                  state_d = RUN;
                  ready_d = 1'b0;
               end
`else
               work_d  = {1'b0, A};
               b_d     = B;
               cnt_d   = CW'(N);
               state_d = RUN;
               ready_d = 1'b0;
`endif
            end
         end
         RUN: begin
            work_d = iter_work;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d     = iter_work[N-1:0];
               r_d     = iter_work[2*N-1:N];
               state_d = DONE;
               ready_d = 1'b1;
`ifdef DIV_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         ready_q <= 1'b1;
`ifdef DIV_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ready_q <= ready_d;
`ifdef DIV_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign Q     = q_q;
   assign R     = r_q;
   assign ready = ready_q;
`ifdef DIV_OVF_EN
   assign ovf   = ovf_q;
`else
   assign ovf   = 1'b0;
`endif

endmodule
